// File: rtl/flow_control_pkg.sv
// rtl/flow_control_pkg.sv - shared types and helpers for the multi-channel flow controller
//
// Purpose: per-channel FSM state encoding, statistics counter width and a
// saturating increment used by the optional pause-cycle counters.
// Ports: none (package).

package flow_control_pkg;

  typedef enum logic {
    FC_RUN    = 1'b0,
    FC_PAUSED = 1'b1
  } fc_state_e;

  localparam int STAT_W = 16;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
//
// Purpose: select the first set request bit at or after ptr, wrapping from
// NCH-1 back to 0. The pointer register itself lives in the parent.
// Ports:
//   req    in   NCH    request vector
//   ptr    in   ID_W   search start index
//   grant  out  NCH    one-hot selection, zero when no request
//   id     out  ID_W   binary index of grant, zero when no request
//   valid  out  1      at least one request present

module rr_arbiter #(
  parameter  int NCH  = 4,
  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req,
  input  logic [ID_W-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/flow_control_mc.sv
// rtl/flow_control_mc.sv - multi-channel FIFO flow controller with round-robin pop selection
//
// Purpose: per channel, a registered pause with hysteresis toward the writer,
// a registered can_pop toward the consumer and sticky overflow/underflow
// flags; one shared consumer is served by a round-robin pick each cycle.
// Optional feature macro: FLOW_CONTROL_STATS_EN adds per-channel 16-bit
// saturating pause-cycle counters on output pause_cycles.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   fifo_count  in  NCH*CNT_W  occupancy, channel i at [i*CNT_W +: CNT_W]
//   fifo_wr     in  NCH        write strobes (error detection only)
//   fifo_rd     in  NCH        read strobes (error detection only)
//   af_thresh   in  CNT_W      almost-full level, shared
//   ae_thresh   in  CNT_W      almost-empty level, shared
//   dest_ready  in  1          consumer accepts one pop this cycle
//   pause       out NCH        per-channel back-pressure
//   can_pop     out NCH        per-channel above almost-empty
//   pop_grant   out NCH        one-hot pop selection, zero when idle
//   pop_id      out ID_W       index of pop_grant, zero when idle
//   err_ovf     out NCH        sticky write-at-full
//   err_unf     out NCH        sticky read-at-empty
//   pause_cycles out NCH*16    (FLOW_CONTROL_STATS_EN only)

module flow_control_mc
  import flow_control_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DEPTH = 8,
  parameter  int HYST  = 1,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int ID_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*CNT_W-1:0] fifo_count,
  input  logic [NCH-1:0]       fifo_wr,
  input  logic [NCH-1:0]       fifo_rd,
  input  logic [CNT_W-1:0]     af_thresh,
  input  logic [CNT_W-1:0]     ae_thresh,
  input  logic                 dest_ready,
  output logic [NCH-1:0]       pause,
  output logic [NCH-1:0]       can_pop,
  output logic [NCH-1:0]       pop_grant,
  output logic [ID_W-1:0]      pop_id,
  output logic [NCH-1:0]       err_ovf,
  output logic [NCH-1:0]       err_unf
`ifdef FLOW_CONTROL_STATS_EN
  ,
  output logic [NCH*STAT_W-1:0] pause_cycles
`endif
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // Threshold math is one bit wider so count+HYST cannot wrap.
  localparam logic [CNT_W:0]   HYST_X   = (CNT_W+1)'(HYST);

  logic [CNT_W:0] af_x;
  assign af_x = {1'b0, af_thresh};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_x;
    logic             full;
    logic             empty;
    logic             go_pause;
    logic             go_run;
    fc_state_e        state;
    logic             can_pop_q;
    logic             ovf_q;
    logic             unf_q;

    assign cnt      = fifo_count[i*CNT_W +: CNT_W];
    assign cnt_x    = {1'b0, cnt};
    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign go_pause = (cnt_x >= af_x) || full;
    assign go_run   = ((cnt_x + HYST_X) < af_x) && !full;

    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= FC_RUN;
        can_pop_q <= 1'b0;
        ovf_q     <= 1'b0;
        unf_q     <= 1'b0;
      end else begin
        case (state)
          FC_RUN:    if (go_pause) state <= FC_PAUSED;
          FC_PAUSED: if (go_run)   state <= FC_RUN;
          default:   state <= FC_RUN;
        endcase
        can_pop_q <= (cnt > ae_thresh) && !empty;
        // A simultaneous write and read at full/empty is a pass-through.
        if (fifo_wr[i] && !fifo_rd[i] && full) ovf_q <= 1'b1;
        if (fifo_rd[i] && !fifo_wr[i] && empty) unf_q <= 1'b1;
      end
    end

    assign pause[i]   = (state == FC_PAUSED);
    assign can_pop[i] = can_pop_q;
    assign err_ovf[i] = ovf_q;
    assign err_unf[i] = unf_q;

`ifdef FLOW_CONTROL_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        stat_q <= '0;
      end else if (state == FC_PAUSED) begin
        stat_q <= sat_inc(stat_q);
      end
    end

    assign pause_cycles[i*STAT_W +: STAT_W] = stat_q;
`endif
  end

  logic [NCH-1:0]  arb_grant;
  logic [ID_W-1:0] arb_id;
  logic            arb_valid;
  logic [ID_W-1:0] ptr;

  // The arbiter looks at the registered can_pop, so a channel becomes
  // eligible one cycle after its count rises above almost-empty.
  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (can_pop),
    .ptr   (ptr),
    .grant (arb_grant),
    .id    (arb_id),
    .valid (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      pop_grant <= '0;
      pop_id    <= '0;
    end else if (dest_ready && arb_valid) begin
      pop_grant <= arb_grant;
      pop_id    <= arb_id;
      ptr       <= (arb_id == ID_W'(NCH - 1)) ? '0 : arb_id + ID_W'(1);
    end else begin
      pop_grant <= '0;
      pop_id    <= '0;
    end
  end

endmodule

// File: tb/tb_flow_control_mc.sv
// tb/tb_flow_control_mc.sv - self-checking bench for flow_control_mc against a behavioural model

module tb_flow_control_mc;

  localparam int NCH = 4;
  localparam int DEPTH = 8;
  localparam int HYST = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fifo_count;
  logic [3:0]  fifo_wr, fifo_rd;
  logic [3:0]  af_thresh, ae_thresh;
  logic        dest_ready;
  logic [3:0]  pause, can_pop, pop_grant, err_ovf, err_unf;
  logic [1:0]  pop_id;
`ifdef FLOW_CONTROL_STATS_EN
  logic [63:0] pause_cycles;
`endif

  flow_control_mc #(.NCH(NCH), .DEPTH(DEPTH), .HYST(HYST)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_count (fifo_count),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .af_thresh  (af_thresh),
    .ae_thresh  (ae_thresh),
    .dest_ready (dest_ready),
    .pause      (pause),
    .can_pop    (can_pop),
    .pop_grant  (pop_grant),
    .pop_id     (pop_id),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf)
`ifdef FLOW_CONTROL_STATS_EN
    ,
    .pause_cycles (pause_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int cnt [NCH];

  // Behavioural model: what each output should read after the next edge.
  bit [3:0] m_pause, m_cp, m_grant, m_ovf, m_unf;
  int       m_id, m_ptr;
  int       m_stat [NCH];

  task automatic step();
    bit [3:0] n_pause, n_cp, n_grant, n_ovf, n_unf;
    int       n_id, n_ptr, j;
    int       n_stat [NCH];
    bit       found;
    for (int i = 0; i < NCH; i++) fifo_count[i*4 +: 4] = cnt[i][3:0];
    n_pause = '0; n_cp = '0; n_grant = '0; n_ovf = m_ovf; n_unf = m_unf;
    n_id = 0; n_ptr = m_ptr;
    if (reset) begin
      n_ovf = '0; n_unf = '0; n_ptr = 0;
      for (int i = 0; i < NCH; i++) n_stat[i] = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m_pause[i])
          n_pause[i] = !((cnt[i] + HYST < int'(af_thresh)) && cnt[i] != DEPTH);
        else
          n_pause[i] = (cnt[i] >= int'(af_thresh)) || cnt[i] == DEPTH;
        n_cp[i] = (cnt[i] > int'(ae_thresh)) && cnt[i] != 0;
        if (fifo_wr[i] && !fifo_rd[i] && cnt[i] == DEPTH) n_ovf[i] = 1'b1;
        if (fifo_rd[i] && !fifo_wr[i] && cnt[i] == 0) n_unf[i] = 1'b1;
        n_stat[i] = m_pause[i] ? ((m_stat[i] < 65535) ? m_stat[i] + 1 : 65535) : m_stat[i];
      end
      found = 1'b0;
      if (dest_ready && m_cp != 0) begin
        for (int k = 0; k < NCH; k++) begin
          j = (m_ptr + k) % NCH;
          if (!found && m_cp[j]) begin
            found = 1'b1;
            n_grant[j] = 1'b1;
            n_id = j;
            n_ptr = (j + 1) % NCH;
          end
        end
      end
    end
    @(posedge clk);
    m_pause = n_pause; m_cp = n_cp; m_grant = n_grant; m_ovf = n_ovf; m_unf = n_unf;
    m_id = n_id; m_ptr = n_ptr;
    for (int i = 0; i < NCH; i++) m_stat[i] = n_stat[i];
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; fifo_wr = '0; fifo_rd = '0; dest_ready = 1'b0;
    af_thresh = 4'd6; ae_thresh = 4'd1;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
  endtask

  task automatic test_reset();
    m_ptr = 0; m_ovf = '0; m_unf = '0;
    for (int i = 0; i < NCH; i++) m_stat[i] = 0;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NCH; i++) cnt[i] = $urandom_range(0, 8);
      fifo_wr = 4'($urandom); fifo_rd = 4'($urandom);
      dest_ready = 1'($urandom); af_thresh = 4'($urandom_range(0, 9));
      ae_thresh = 4'($urandom_range(0, 9));
      step();
    end
    n_cmp++;
    if ({pause, can_pop, pop_grant, err_ovf, err_unf, pop_id} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs got pause=%b can_pop=%b grant=%b ovf=%b unf=%b id=%0d want all 0",
               pause, can_pop, pop_grant, err_ovf, err_unf, pop_id);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_hysteresis();
    int       seq [4] = '{5, 6, 5, 4};
    bit       exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      cnt[0] = seq[s];
      step();
      n_cmp++;
      if (pause[0] !== exp[s]) begin
        n_err++;
        $display("FAIL hysteresis_step%0d count=%0d pause0 got %b want %b", s, seq[s], pause[0], exp[s]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_b [5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    logic [1:0] eid;
    for (int i = 0; i < NCH; i++) cnt[i] = 4;
    dest_ready = 1'b0;
    step();
    dest_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      eid = 2'($clog2(exp_a[s]));
      n_cmp++;
      if (pop_grant !== exp_a[s] || pop_id !== eid) begin
        n_err++;
        $display("FAIL rr_all%0d grant=%b id=%0d want %b id=%0d", s, pop_grant, pop_id, exp_a[s], eid);
      end
    end
    cnt[2] = 0;
    for (int s = 0; s < 5; s++) begin
      step();
      eid = 2'($clog2(exp_b[s]));
      n_cmp++;
      if (pop_grant !== exp_b[s] || pop_id !== eid) begin
        n_err++;
        $display("FAIL rr_skip2_%0d grant=%b id=%0d want %b id=%0d", s, pop_grant, pop_id, exp_b[s], eid);
      end
    end
  endtask

  task automatic test_stall();
    dest_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++;
      if (pop_grant !== 4'b0000 || pop_id !== 2'd0) begin
        n_err++;
        $display("FAIL stall%0d grant=%b id=%0d want 0000 id=0", s, pop_grant, pop_id);
      end
    end
    dest_ready = 1'b1;
    step();
    n_cmp++;
    if (pop_grant !== 4'b0001) begin
      n_err++;
      $display("FAIL stall_resume grant=%b want 0001", pop_grant);
    end
    dest_ready = 1'b0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    step();
  endtask

  task automatic test_errors();
    cnt[1] = 8; fifo_wr[1] = 1'b1; fifo_rd[1] = 1'b1;
    step();
    n_cmp++;
    if (err_ovf !== 4'b0000) begin
      n_err++;
      $display("FAIL ovf_passthrough err_ovf=%b want 0000", err_ovf);
    end
    fifo_rd[1] = 1'b0;
    step();
    n_cmp++;
    if (err_ovf !== 4'b0010) begin
      n_err++;
      $display("FAIL ovf_set err_ovf=%b want 0010", err_ovf);
    end
    fifo_wr[1] = 1'b0; cnt[1] = 3;
    step(); step();
    n_cmp++;
    if (err_ovf !== 4'b0010) begin
      n_err++;
      $display("FAIL ovf_sticky err_ovf=%b want 0010", err_ovf);
    end
    cnt[3] = 0; fifo_rd[3] = 1'b1;
    cnt[0] = 0; fifo_wr[0] = 1'b1; fifo_rd[0] = 1'b1;
    step();
    n_cmp++;
    if (err_unf !== 4'b1000) begin
      n_err++;
      $display("FAIL unf_set err_unf=%b want 1000", err_unf);
    end
    fifo_wr = '0; fifo_rd = '0;
    step();
  endtask

  task automatic test_thresholds();
    af_thresh = 4'd0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NCH; i++) cnt[i] = $urandom_range(0, 8);
      step();
    end
    n_cmp++;
    if (pause !== 4'b1111) begin
      n_err++;
      $display("FAIL af_zero pause=%b want 1111", pause);
    end
    af_thresh = 4'd6; ae_thresh = 4'd8;
    for (int i = 0; i < NCH; i++) cnt[i] = 8;
    step();
    n_cmp++;
    if (can_pop !== 4'b0000) begin
      n_err++;
      $display("FAIL ae_depth can_pop=%b want 0000", can_pop);
    end
    ae_thresh = 4'd1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++) cnt[i] = $urandom_range(0, 8);
      fifo_wr = 4'($urandom); fifo_rd = 4'($urandom);
      dest_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) af_thresh = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 15) == 0) ae_thresh = 4'($urandom_range(0, 9));
      step();
      n_cmp++;
      if (pause !== m_pause || can_pop !== m_cp) begin
        n_err++;
        $display("FAIL rand%0d_flow pause=%b can_pop=%b want %b %b", c, pause, can_pop, m_pause, m_cp);
      end
      n_cmp++;
      if (pop_grant !== m_grant || pop_id !== 2'(m_id)) begin
        n_err++;
        $display("FAIL rand%0d_arb grant=%b id=%0d want %b id=%0d", c, pop_grant, pop_id, m_grant, m_id);
      end
      n_cmp++;
      if (err_ovf !== m_ovf || err_unf !== m_unf) begin
        n_err++;
        $display("FAIL rand%0d_err ovf=%b unf=%b want %b %b", c, err_ovf, err_unf, m_ovf, m_unf);
      end
    end
    idle_inputs();
  endtask

`ifdef FLOW_CONTROL_STATS_EN
  task automatic test_stats();
    reset = 1'b1; step(); reset = 1'b0;
    cnt[2] = 8;
    for (int c = 0; c < 70000; c++) step();
    n_cmp++;
    if (pause_cycles[47:32] !== 16'hFFFF || int'(pause_cycles[47:32]) != m_stat[2]) begin
      n_err++;
      $display("FAIL stats_sat ch2=%0d want 65535", pause_cycles[47:32]);
    end
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++;
    if (pause_cycles !== 64'd0) begin
      n_err++;
      $display("FAIL stats_reset pause_cycles=%h want 0", pause_cycles);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_hysteresis();
    test_round_robin();
    test_stall();
    test_errors();
    test_thresholds();
    test_random();
`ifdef FLOW_CONTROL_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
